// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED fader stage.
package led_pkg;

   localparam int CLK_HZ       = 12_000_000;
   localparam int NUM_LEDS_DEF = 5;

   // Full-scale brightness for a given PWM resolution.
   function automatic int max_level(input int pwm_bits);
      return (1 << pwm_bits) - 1;
   endfunction

endpackage

// File: rtl/led_fader_if.sv
// Pattern-in / LED-out bundle for the fader, plus debug taps of internal state.
interface led_fader_if
   import led_pkg::*;
#(
   parameter int NUM_LEDS = NUM_LEDS_DEF,
   parameter int PWM_BITS = 8
);
   // No handshake: pattern_in is sampled on every clk edge and led_out updates every edge.
   logic [NUM_LEDS-1:0]          pattern_in;
   logic [NUM_LEDS-1:0]          led_out;
   logic [NUM_LEDS*PWM_BITS-1:0] dbg_level;
   logic [PWM_BITS-1:0]          dbg_pwm_cnt;
   logic                         dbg_tick;

   modport master (
      output pattern_in,
      input  led_out, dbg_level, dbg_pwm_cnt, dbg_tick
   );

   modport slave (
      input  pattern_in,
      output led_out, dbg_level, dbg_pwm_cnt, dbg_tick
   );
endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level with refresh/decay priority and a registered PWM compare.
module led_fade_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS   = 8,
   parameter int DECAY_STEP = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set_i,
   input  logic                tick_i,
   input  logic [PWM_BITS-1:0] pwm_cnt_i,
   output logic                led_o,
   output logic [PWM_BITS-1:0] level_o
);
   localparam logic [PWM_BITS-1:0] MAX  = PWM_BITS'(max_level(PWM_BITS));
   localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

   logic [PWM_BITS-1:0] level_q, level_d;
   logic                led_q, led_d;

   // A set bit wins over a coincident tick; the compare guards the subtract from underflow.
   always_comb begin
      level_d = level_q;
      if (set_i) begin
         level_d = MAX;
      end else if (tick_i) begin
         level_d = (level_q >= STEP) ? (level_q - STEP) : '0;
      end
   end

   assign led_d = (level_q > pwm_cnt_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= '0;
         led_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         led_q   <= led_d;
      end
   end

   assign led_o   = led_q;
   assign level_o = level_q;
endmodule

// File: rtl/led_fader.sv
// Comet-tail LED driver: per-LED brightness decays linearly after its pattern bit drops.
module led_fader
   import led_pkg::*;
#(
   parameter int NUM_LEDS   = NUM_LEDS_DEF,
   parameter int PWM_BITS   = 8,
   parameter int DECAY_DIV  = 300000,
   parameter int DECAY_STEP = 16
) (
   input  logic        clk,
   input  logic        rst,
   led_fader_if.slave  fader_if
);
   localparam logic [PWM_BITS-1:0] MAX      = PWM_BITS'(max_level(PWM_BITS));
   localparam int                  DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);

   logic [DIV_W-1:0]             div_cnt_q, div_cnt_d;
   logic [PWM_BITS-1:0]          pwm_cnt_q, pwm_cnt_d;
   logic                         tick;
   logic [NUM_LEDS-1:0]          led_w;
   logic [NUM_LEDS*PWM_BITS-1:0] level_w;

   assign tick      = (div_cnt_q == DIV_LAST);
   assign div_cnt_d = tick ? '0 : (div_cnt_q + 1'b1);
   // PWM period is MAX cycles so level MAX is solid on and level 0 solid off.
   assign pwm_cnt_d = (pwm_cnt_q == (MAX - 1'b1)) ? '0 : (pwm_cnt_q + 1'b1);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q <= '0;
         pwm_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_fade_channel #(
         .PWM_BITS   (PWM_BITS),
         .DECAY_STEP (DECAY_STEP)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .set_i     (fader_if.pattern_in[i]),
         .tick_i    (tick),
         .pwm_cnt_i (pwm_cnt_q),
         .led_o     (led_w[i]),
         .level_o   (level_w[i*PWM_BITS +: PWM_BITS])
      );
   end

   assign fader_if.led_out     = led_w;
   assign fader_if.dbg_level   = level_w;
   assign fader_if.dbg_pwm_cnt = pwm_cnt_q;
   assign fader_if.dbg_tick    = tick;
endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: three instances (base, saturating step, slow duty) checked by a scoreboard.
module tb_led_fader;

   localparam int K_LED  = 0;
   localparam int K_LVL  = 1;
   localparam int K_PWM  = 2;
   localparam int K_TICK = 3;
   localparam int K_WIN  = 4;

   typedef struct {
      int    cyc;
      int    dut;
      int    kind;
      int    ch;
      int    exp;
      string name;
   } chk_t;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_bc;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit [14:0] hist_c = '0;
   chk_t exp_q[$];

   led_fader_if #(.NUM_LEDS(5), .PWM_BITS(4)) if_a ();
   led_fader_if #(.NUM_LEDS(5), .PWM_BITS(4)) if_b ();
   led_fader_if #(.NUM_LEDS(5), .PWM_BITS(4)) if_c ();

   led_fader #(.NUM_LEDS(5), .PWM_BITS(4), .DECAY_DIV(4), .DECAY_STEP(4)) u_a (
      .clk(clk), .rst(rst_a), .fader_if(if_a));
   led_fader #(.NUM_LEDS(5), .PWM_BITS(4), .DECAY_DIV(4), .DECAY_STEP(6)) u_b (
      .clk(clk), .rst(rst_bc), .fader_if(if_b));
   led_fader #(.NUM_LEDS(5), .PWM_BITS(4), .DECAY_DIV(64), .DECAY_STEP(4)) u_c (
      .clk(clk), .rst(rst_bc), .fader_if(if_c));

   // clock / cycle count: cyc = number of rising edges seen so far
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void expect_at(input int c, input int d, input int k, input int ch,
                                     input int e, input string n);
      chk_t t;
      t.cyc = c; t.dut = d; t.kind = k; t.ch = ch; t.exp = e; t.name = n;
      exp_q.push_back(t);
   endfunction

   function automatic int sample(input int d, input int k, input int ch);
      logic [4:0]  led;
      logic [19:0] lv;
      logic [3:0]  pw;
      logic        tk;
      case (d)
         0:       begin led = if_a.led_out; lv = if_a.dbg_level; pw = if_a.dbg_pwm_cnt; tk = if_a.dbg_tick; end
         1:       begin led = if_b.led_out; lv = if_b.dbg_level; pw = if_b.dbg_pwm_cnt; tk = if_b.dbg_tick; end
         default: begin led = if_c.led_out; lv = if_c.dbg_level; pw = if_c.dbg_pwm_cnt; tk = if_c.dbg_tick; end
      endcase
      case (k)
         K_LED:   return int'(led);
         K_LVL:   return int'(lv[ch*4 +: 4]);
         K_PWM:   return int'(pw);
         K_TICK:  return int'(tk);
         default: return $countones(hist_c);
      endcase
   endfunction

   // monitor: sample mid-cycle, pop every expectation due now
   always @(negedge clk) begin
      int act;
      hist_c = {hist_c[13:0], (if_c.led_out[1] === 1'b1)};
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].cyc <= cyc) begin
            checks++;
            act = sample(exp_q[i].dut, exp_q[i].kind, exp_q[i].ch);
            if (exp_q[i].cyc < cyc) begin
               errors++;
               $display("FAIL %s: check due at cycle %0d was missed", exp_q[i].name, exp_q[i].cyc);
            end else if (act != exp_q[i].exp) begin
               errors++;
               $display("FAIL %s @cyc %0d: got %0d expected %0d", exp_q[i].name, cyc, act, exp_q[i].exp);
            end
            exp_q.delete(i);
         end
      end
   end

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_a  = 1'b1;
      rst_bc = 1'b1;
      if_a.pattern_in = 5'b11111;
      if_b.pattern_in = 5'b00000;
      if_c.pattern_in = 5'b00000;

      // reset with all-ones pattern; release after edge 3, decay ticks then land on edges 7, 11, ...
      for (int c = 1; c <= 4; c++) expect_at(c, 0, K_LED, 0, 0, "rst_led_off");
      expect_at(3, 0, K_PWM, 0, 0, "rst_pwm_zero");
      expect_at(4, 0, K_LVL, 0, 15, "rel_lvl0_max");
      expect_at(4, 0, K_LVL, 4, 15, "rel_lvl4_max");
      for (int c = 5; c <= 7; c++) expect_at(c, 0, K_LED, 0, 31, "all_on");
      expect_at(4, 0, K_PWM, 0, 1, "pwm_count");
      expect_at(17, 0, K_PWM, 0, 14, "pwm_top");
      expect_at(18, 0, K_PWM, 0, 0, "pwm_wrap");
      expect_at(6, 0, K_LVL, 3, 15, "fade_hold");
      expect_at(7, 0, K_LVL, 3, 11, "fade_11");
      expect_at(11, 0, K_LVL, 1, 7, "fade_7");
      expect_at(15, 0, K_LVL, 2, 3, "fade_3");
      expect_at(19, 0, K_LVL, 4, 0, "fade_0");
      expect_at(20, 0, K_LED, 0, 0, "fade_led_off");

      // single pulse on bit 0, sampled at edge 25
      expect_at(25, 0, K_LED, 0, 0, "pulse_latency");
      expect_at(25, 0, K_LVL, 0, 15, "pulse_15");
      expect_at(26, 0, K_LED, 0, 1, "pulse_led_on");
      expect_at(26, 0, K_LVL, 0, 15, "pulse_hold");
      expect_at(27, 0, K_LED, 0, 1, "pulse_led_on2");
      expect_at(27, 0, K_LVL, 0, 11, "pulse_11");
      expect_at(30, 0, K_LVL, 0, 11, "pulse_hold11");
      expect_at(31, 0, K_LVL, 0, 7, "pulse_7");
      expect_at(35, 0, K_LVL, 0, 3, "pulse_3");
      expect_at(38, 0, K_LVL, 0, 3, "pulse_hold3");
      expect_at(39, 0, K_LVL, 0, 0, "pulse_0");
      expect_at(45, 0, K_LVL, 0, 0, "pulse_stay0");
      expect_at(40, 0, K_LED, 0, 0, "pulse_led_off");
      expect_at(41, 0, K_LED, 0, 0, "pulse_led_off2");

      // bit 2 held across ticks at edges 47, 51, 55; dropped before edge 57
      for (int c = 45; c <= 58; c++) expect_at(c, 0, K_LVL, 2, 15, "prio_lvl");
      for (int c = 46; c <= 58; c++) expect_at(c, 0, K_LED, 0, 4, "prio_led");
      expect_at(59, 0, K_LVL, 2, 11, "prio_first_dec");

      // pulse bit 1 then reset at edge 73 while level1 = 7
      expect_at(72, 0, K_LVL, 1, 7, "pre_rst_lvl7");
      expect_at(72, 0, K_PWM, 0, 9, "pre_rst_pwm");
      expect_at(73, 0, K_LVL, 1, 0, "midrst_lvl");
      expect_at(73, 0, K_PWM, 0, 0, "midrst_pwm");
      expect_at(73, 0, K_LED, 0, 0, "midrst_led");
      expect_at(74, 0, K_PWM, 0, 1, "post_rst_pwm");
      expect_at(74, 0, K_TICK, 0, 0, "post_rst_tick74");
      expect_at(75, 0, K_TICK, 0, 0, "post_rst_tick75");
      expect_at(76, 0, K_TICK, 0, 1, "post_rst_tick76");
      expect_at(77, 0, K_TICK, 0, 0, "post_rst_tick77");
      expect_at(80, 0, K_LED, 0, 0, "no_glow");

      // saturation: step 6, pulse sampled at edge 9
      expect_at(9, 1, K_LVL, 0, 15, "sat_15");
      expect_at(10, 1, K_LED, 0, 1, "sat_led_on");
      expect_at(11, 1, K_LVL, 0, 9, "sat_9");
      expect_at(14, 1, K_LVL, 0, 9, "sat_hold9");
      expect_at(15, 1, K_LVL, 0, 3, "sat_3");
      expect_at(19, 1, K_LVL, 0, 0, "sat_0");
      expect_at(23, 1, K_LVL, 0, 0, "sat_stay0");
      expect_at(27, 1, K_LVL, 0, 0, "sat_stay0b");
      expect_at(20, 1, K_LED, 0, 0, "sat_led_off");
      expect_at(24, 1, K_LED, 0, 0, "sat_led_off2");

      // duty: divider 64, pulse bit 1 sampled at edge 11, decays at edges 67, 131, 195, 259
      expect_at(65, 2, K_TICK, 0, 0, "duty_tick65");
      expect_at(66, 2, K_TICK, 0, 1, "duty_tick66");
      expect_at(66, 2, K_LVL, 1, 15, "duty_lvl15");
      expect_at(67, 2, K_LVL, 1, 11, "duty_lvl11");
      expect_at(130, 2, K_LVL, 1, 11, "duty_lvl11b");
      expect_at(131, 2, K_LVL, 1, 7, "duty_lvl7");
      expect_at(195, 2, K_LVL, 1, 3, "duty_lvl3");
      expect_at(259, 2, K_LVL, 1, 0, "duty_lvl0");
      expect_at(30, 2, K_WIN, 0, 15, "duty_win15");
      expect_at(90, 2, K_WIN, 0, 11, "duty_win11");
      expect_at(131, 2, K_WIN, 0, 11, "duty_win11b");
      expect_at(160, 2, K_WIN, 0, 7, "duty_win7");
      expect_at(230, 2, K_WIN, 0, 3, "duty_win3");
      expect_at(280, 2, K_WIN, 0, 0, "duty_win0");

      // driver
      goto(3);  rst_a = 1'b0; rst_bc = 1'b0;
      goto(5);  if_a.pattern_in = 5'b00000;
      goto(8);  if_b.pattern_in = 5'b00001;
      goto(9);  if_b.pattern_in = 5'b00000;
      goto(10); if_c.pattern_in = 5'b00010;
      goto(11); if_c.pattern_in = 5'b00000;
      goto(24); if_a.pattern_in = 5'b00001;
      goto(25); if_a.pattern_in = 5'b00000;
      goto(44); if_a.pattern_in = 5'b00100;
      goto(56); if_a.pattern_in = 5'b00000;
      goto(64); if_a.pattern_in = 5'b00010;
      goto(65); if_a.pattern_in = 5'b00000;
      goto(72); rst_a = 1'b1;
      goto(73); rst_a = 1'b0;
      goto(300);
      @(negedge clk);
      #1;

      // report
      while (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: check due at cycle %0d never ran", exp_q[0].name, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
